// File: rtl/button_debouncer.sv
// Two-button debouncer: per-button 2-flop synchronizer feeding a counter-based debounce FSM.
// Optional BUTTON_DEBOUNCER_PRESS_PULSE_EN adds one-cycle registered press pulses.

module button_debouncer_chan #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_WIDTH       = 19
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic raw,
`ifdef BUTTON_DEBOUNCER_PRESS_PULSE_EN
  output logic press,
`endif
  output logic level
);

  // Bit 1 of the encoding is the debounced level, so the output is a plain state flop.
  typedef enum logic [1:0] {
    STABLE_LOW  = 2'b00,
    WAIT_HIGH   = 2'b01,
    STABLE_HIGH = 2'b10,
    WAIT_LOW    = 2'b11
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LAST      = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam bit                   IMMEDIATE = (DEBOUNCE_CYCLES == 1);

  logic                 s1, s2;
  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= STABLE_LOW;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      STABLE_LOW: begin
        if (s2) begin
          if (IMMEDIATE) begin
            state_nxt = STABLE_HIGH;
          end else begin
            state_nxt = WAIT_HIGH;
            cnt_nxt   = CNT_ONE;
          end
        end
      end
      WAIT_HIGH: begin
        if (!s2) begin
          state_nxt = STABLE_LOW;
          cnt_nxt   = '0;
        end else if (cnt == LAST) begin
          state_nxt = STABLE_HIGH;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      STABLE_HIGH: begin
        if (!s2) begin
          if (IMMEDIATE) begin
            state_nxt = STABLE_LOW;
          end else begin
            state_nxt = WAIT_LOW;
            cnt_nxt   = CNT_ONE;
          end
        end
      end
      WAIT_LOW: begin
        if (s2) begin
          state_nxt = STABLE_HIGH;
          cnt_nxt   = '0;
        end else if (cnt == LAST) begin
          state_nxt = STABLE_LOW;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = STABLE_LOW;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign level = state[1];

`ifdef BUTTON_DEBOUNCER_PRESS_PULSE_EN
  // Registered off the next-state decode so the pulse lands on the same edge as the rise.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      press <= 1'b0;
    end else begin
      press <= ~state[1] & state_nxt[1];
    end
  end
`endif

endmodule

module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_WIDTH       = 19
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic RAW_LEFT,
  input  logic RAW_RIGHT,
  output logic BTN_LEFT,
`ifdef BUTTON_DEBOUNCER_PRESS_PULSE_EN
  output logic BTN_LEFT_PRESS,
  output logic BTN_RIGHT_PRESS,
`endif
  output logic BTN_RIGHT
);

  button_debouncer_chan #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_WIDTH      (CNT_WIDTH)
  ) u_left (
    .CLK    (CLK),
    .RESET_N(RESET_N),
    .raw    (RAW_LEFT),
`ifdef BUTTON_DEBOUNCER_PRESS_PULSE_EN
    .press  (BTN_LEFT_PRESS),
`endif
    .level  (BTN_LEFT)
  );

  button_debouncer_chan #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_WIDTH      (CNT_WIDTH)
  ) u_right (
    .CLK    (CLK),
    .RESET_N(RESET_N),
    .raw    (RAW_RIGHT),
`ifdef BUTTON_DEBOUNCER_PRESS_PULSE_EN
    .press  (BTN_RIGHT_PRESS),
`endif
    .level  (BTN_RIGHT)
  );

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Conditions the two raw board push-buttons before they reach the paddle/game-logic stage.
- Per button: 2-flop synchronizer, then a debounce FSM with a counter.
- Outputs clean, glitch-free level signals BTN_LEFT / BTN_RIGHT, which the game-logic stage samples during its update window.
- Buttons are fully independent; resolving simultaneous presses is the consumer's job.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive synchronized samples that must disagree with the stable level before the output flips (10 ms at 50 MHz); legal range 1 .. 2^CNT_WIDTH-1.
- CNT_WIDTH, 19, width of each debounce counter.

Ports:
- CLK  in  1  system clock.
- RESET_N  in  1  asynchronous, active-low reset.
- RAW_LEFT  in  1  raw left button, active-high, asynchronous to CLK, bouncy.
- RAW_RIGHT  in  1  raw right button, active-high, asynchronous to CLK, bouncy.
- BTN_LEFT  out  1  debounced left level, registered.
- BTN_RIGHT  out  1  debounced right level, registered.

Behaviour:
- Reset
  - RESET_N low clears, asynchronously: sync flops, counters, FSMs (to STABLE_LOW) and all outputs (to 0).
  - Asserting reset mid-count discards the count; no output pulse or glitch.
  - Reset is released synchronously to CLK by the system; the block needs no internal release logic.
- Synchronizer
  - RAW_x goes into s1 then s2, two flops on CLK.
  - Only s2 is used downstream; raw inputs never reach the FSM or counter directly.
- Per-button FSM states: STABLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW. Transitions:
  - STABLE_LOW with s2=1: go to WAIT_HIGH; counter := 1.
  - STABLE_HIGH with s2=0: go to WAIT_LOW; counter := 1.
  - WAIT_x with s2 back at the stable level: return to the stable state; counter := 0; output unchanged.
  - WAIT_x with s2 still differing and counter == DEBOUNCE_CYCLES-1: enter the opposite STABLE state; output flips on this edge; counter := 0.
  - WAIT_x otherwise: counter := counter+1.
- DEBOUNCE_CYCLES = 1 special case:
  - The first differing sample flips the output directly from the STABLE state; WAIT is skipped.
- Latency
  - Raw change is set up before edge 0 and then held.
  - The output changes at edge DEBOUNCE_CYCLES+1.
  - Any bounce back resets the count, so the latency restarts from the last transition.
- Counter arithmetic
  - Unsigned, CNT_WIDTH bits.
  - Never exceeds DEBOUNCE_CYCLES-1, so it never wraps.
  - Compare is against the parameter truncated to CNT_WIDTH; out-of-range parameters are illegal.
- Outputs
  - Driven straight from the FSM state register, so glitch-free.
  - Changes only on CLK rising edges.
- Simultaneous events
  - Both buttons may flip on the same edge.
  - Each FSM ignores the other button completely.

Optional Feature:
- Macro: BUTTON_DEBOUNCER_PRESS_PULSE_EN.
- Defined: adds outputs BTN_LEFT_PRESS and BTN_RIGHT_PRESS (out, 1 bit each).
  - Each is a registered one-cycle pulse, high on exactly the edge where its debounced level rises 0->1.
  - Pulses coincide with the level change; none are generated on release.
  - Both reset to 0.
- Undefined: the ports and their logic are absent; levels-only behaviour is identical.

Test Plan:
- Reset, clean press, clean release (DEBOUNCE_CYCLES=4):
  - RESET_N=0 with RAW_LEFT=1 -> BTN_LEFT=0 throughout reset.
  - Release reset, then RAW_LEFT 0->1 before edge 0 and held -> BTN_LEFT=0 through edge 4, 1 after edge 5.
  - Clean release -> BTN_LEFT falls after edge 5.
- Bounce (DEBOUNCE_CYCLES=4):
  - RAW_RIGHT pattern 1,1,0,1,1,1,1,1 (one value per cycle) -> BTN_RIGHT rises 5 edges after the last 0->1 transition, not earlier.
  - A 3-cycle high glitch -> BTN_RIGHT stays 0.
- Both buttons: RAW_LEFT and RAW_RIGHT rise together (DEBOUNCE_CYCLES=4) -> BTN_LEFT and BTN_RIGHT rise on the same edge.
- Reset mid-count: RAW_LEFT held high, RESET_N pulsed low after 3 cycles in WAIT_HIGH -> after release, the output rises only after a full DEBOUNCE_CYCLES+1 edges.
- Minimum parameter: DEBOUNCE_CYCLES=1, RAW_LEFT rises before edge 0 -> BTN_LEFT high after edge 2.
- Press pulse (macro defined, DEBOUNCE_CYCLES=4):
  - Press and hold RAW_LEFT -> BTN_LEFT_PRESS high for exactly the cycle after edge 5.
  - No pulse on release.
  - Macro undefined -> build with no such ports, level results unchanged.
